// File: rtl/dp_pkg.sv
// Purpose: shared constants and stage payload widths for the circuit2_pipe datapath.
// Latency: n/a (package only).
// Backpressure: n/a. Optional feature macro: CIRCUIT2_PIPE_OVF_EN adds one overflow bit per payload.
package dp_pkg;

  localparam int C2P_STAGES  = 3;
  localparam int C2P_LATENCY = 3;

`ifdef CIRCUIT2_PIPE_OVF_EN
  localparam int C2P_OVF_W = 1;
`else
  localparam int C2P_OVF_W = 0;
`endif

  // Stage 1 payload: {d, e, f[, o]}
  function automatic int c2p_s1_w(input int dw);
    return 3 * dw + C2P_OVF_W;
  endfunction

  // Stage 2 payload: {g, h, lt, eq[, o]}
  function automatic int c2p_s2_w(input int dw);
    return 2 * dw + 2 + C2P_OVF_W;
  endfunction

  // Stage 3 payload: {x, z[, o]}
  function automatic int c2p_s3_w(input int dw);
    return 2 * dw + C2P_OVF_W;
  endfunction

endpackage

// File: rtl/dp_pipe_stage.sv
// Purpose: generic valid/ready register slice carrying WIDTH bits of payload.
// Latency: 1 cycle from load to valid.
// Backpressure: loads when empty or when the downstream slice loads this cycle; holds otherwise.
// Ports: clk/rst_n (sync, active-low); src_valid/src_data upstream; load = upstream ready;
//        sink_load = downstream load condition; valid/data = registered output.
module dp_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             load,
  input  logic             sink_load,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // An empty slice always loads, so bubbles collapse under a stalled sink.
  assign load = !valid || sink_load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= src_valid;
      // Payload only moves with real data, so outputs hold across bubbles.
      if (src_valid) begin
        data <= src_data;
      end
    end
  end

endmodule

// File: rtl/circuit2_pipe.sv
// Purpose: three-stage pipelined Circuit2 datapath (d/e/f -> g/h/lt/eq -> x/z).
// Latency: 3 cycles accept->out_valid; 1 result/cycle while out_ready=1.
// Backpressure: in_ready derived from stage valids and out_ready only; full pipe holds when out_ready=0.
// Ports: Clk, Rst (sync, active-low); in_valid/in_ready/a/b/c operand side;
//        out_valid/out_ready/x/z result side; ovf exists only with CIRCUIT2_PIPE_OVF_EN defined.
module circuit2_pipe
  import dp_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int SIGNED    = 0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] x,
  output logic [DATAWIDTH-1:0] z
`ifdef CIRCUIT2_PIPE_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int DW  = DATAWIDTH;
  localparam int S1W = c2p_s1_w(DW);
  localparam int S2W = c2p_s2_w(DW);
  localparam int S3W = c2p_s3_w(DW);

  typedef struct packed {
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    logic [DW-1:0] f;
`ifdef CIRCUIT2_PIPE_OVF_EN
    logic          o;
`endif
  } s1_t;

  typedef struct packed {
    logic [DW-1:0] g;
    logic [DW-1:0] h;
    logic          lt;
    logic          eq;
`ifdef CIRCUIT2_PIPE_OVF_EN
    logic          o;
`endif
  } s2_t;

  typedef struct packed {
    logic [DW-1:0] x;
    logic [DW-1:0] z;
`ifdef CIRCUIT2_PIPE_OVF_EN
    logic          o;
`endif
  } s3_t;

  logic [C2P_STAGES-1:0] vld;
  logic [C2P_STAGES-1:0] ld;

  s1_t s1_nxt, s1_q;
  s2_t s2_nxt, s2_q;
  s3_t s3_nxt, s3_q;

  logic [S1W-1:0] s1_dat;
  logic [S2W-1:0] s2_dat;
  logic [S3W-1:0] s3_dat;

  // ---------------- S1: add/sub (carry dropped) ----------------
`ifdef CIRCUIT2_PIPE_OVF_EN
  logic [DW:0] sum_ab, sum_ac;
  assign sum_ab = {1'b0, a} + {1'b0, b};
  assign sum_ac = {1'b0, a} + {1'b0, c};
`endif

  always_comb begin
    s1_nxt   = '0;
    s1_nxt.d = a + b;
    s1_nxt.e = a + c;
    s1_nxt.f = a - b;
`ifdef CIRCUIT2_PIPE_OVF_EN
    if (SIGNED != 0) begin
      // Two's-complement overflow: result sign disagrees with what the operand signs allow.
      s1_nxt.o = ((a[DW-1] == b[DW-1]) && (s1_nxt.d[DW-1] != a[DW-1]))
               | ((a[DW-1] == c[DW-1]) && (s1_nxt.e[DW-1] != a[DW-1]))
               | ((a[DW-1] != b[DW-1]) && (s1_nxt.f[DW-1] != a[DW-1]));
    end else begin
      s1_nxt.o = sum_ab[DW] | sum_ac[DW] | (a < b);
    end
`endif
  end

  dp_pipe_stage #(.WIDTH(S1W)) u_st1 (
    .clk       (Clk),
    .rst_n     (Rst),
    .src_valid (in_valid),
    .src_data  (s1_nxt),
    .load      (ld[0]),
    .sink_load (ld[1]),
    .valid     (vld[0]),
    .data      (s1_dat)
  );

  assign s1_q = s1_dat;

  // ---------------- S2: compare and select ----------------
  always_comb begin
    s2_nxt = '0;
    if (SIGNED != 0) begin
      s2_nxt.lt = $signed(s1_q.d) < $signed(s1_q.e);
    end else begin
      s2_nxt.lt = s1_q.d < s1_q.e;
    end
    s2_nxt.eq = (s1_q.d == s1_q.e);
    s2_nxt.g  = s2_nxt.lt ? s1_q.d : s1_q.e;
    s2_nxt.h  = s2_nxt.eq ? s2_nxt.g : s1_q.f;
`ifdef CIRCUIT2_PIPE_OVF_EN
    s2_nxt.o  = s1_q.o;
`endif
  end

  dp_pipe_stage #(.WIDTH(S2W)) u_st2 (
    .clk       (Clk),
    .rst_n     (Rst),
    .src_valid (vld[0]),
    .src_data  (s2_nxt),
    .load      (ld[1]),
    .sink_load (ld[2]),
    .valid     (vld[1]),
    .data      (s2_dat)
  );

  assign s2_q = s2_dat;

  // ---------------- S3: shifts ----------------
  always_comb begin
    s3_nxt   = '0;
    s3_nxt.x = s2_q.g << s2_q.lt;
    if (SIGNED != 0) begin
      // Kept as its own statement so the signed operand keeps >>> arithmetic.
      s3_nxt.z = $signed(s2_q.h) >>> s2_q.eq;
    end else begin
      s3_nxt.z = s2_q.h >> s2_q.eq;
    end
`ifdef CIRCUIT2_PIPE_OVF_EN
    s3_nxt.o = s2_q.o;
`endif
  end

  dp_pipe_stage #(.WIDTH(S3W)) u_st3 (
    .clk       (Clk),
    .rst_n     (Rst),
    .src_valid (vld[1]),
    .src_data  (s3_nxt),
    .load      (ld[2]),
    .sink_load (out_ready),
    .valid     (vld[2]),
    .data      (s3_dat)
  );

  assign s3_q      = s3_dat;
  assign in_ready  = ld[0];
  assign out_valid = vld[2];
  assign x         = s3_q.x;
  assign z         = s3_q.z;
`ifdef CIRCUIT2_PIPE_OVF_EN
  assign ovf       = s3_q.o;
`endif

endmodule

// File: tb/tb_circuit2_pipe.sv
// Bench for circuit2_pipe: one unsigned and one signed instance driven in lockstep,
// checked against an integer-arithmetic reference model and an occupancy-count view of flow control.
module tb_circuit2_pipe;

  logic        Clk;
  logic        Rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a, b, c;
  logic        in_ready_u, in_ready_s, out_valid_u, out_valid_s;
  logic [31:0] x_u, z_u, x_s, z_s;
`ifdef CIRCUIT2_PIPE_OVF_EN
  logic        ovf_u, ovf_s;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit [31:0] x;
    bit [31:0] z;
    bit        o;
  } res_t;

  circuit2_pipe #(.DATAWIDTH(32), .SIGNED(0)) dut_u (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready_u),
    .a(a), .b(b), .c(c), .out_valid(out_valid_u), .out_ready(out_ready),
    .x(x_u), .z(z_u)
`ifdef CIRCUIT2_PIPE_OVF_EN
    , .ovf(ovf_u)
`endif
  );

  circuit2_pipe #(.DATAWIDTH(32), .SIGNED(1)) dut_s (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .c(c), .out_valid(out_valid_s), .out_ready(out_ready),
    .x(x_s), .z(z_s)
`ifdef CIRCUIT2_PIPE_OVF_EN
    , .ovf(ovf_s)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reduce an exact integer to 32 bits, reinterpreted as signed when sgn is set.
  function automatic longint wrap(input longint v, input bit sgn);
    longint m;
    m = v & 64'hFFFF_FFFF;
    if (sgn && m >= 64'sh8000_0000) m = m - 64'sh1_0000_0000;
    return m;
  endfunction

  // Reference: exact arithmetic on the operand values, then wrapped.
  function automatic res_t model(input bit [31:0] ia, ib, ic, input bit sgn);
    longint la, lb, lc, s_ab, s_ac, s_f, d, e, f, g, h, xv, zv;
    bit lt, eq;
    res_t r;
    if (sgn) begin
      la = longint'($signed(ia)); lb = longint'($signed(ib)); lc = longint'($signed(ic));
    end else begin
      la = longint'(ia); lb = longint'(ib); lc = longint'(ic);
    end
    s_ab = la + lb; s_ac = la + lc; s_f = la - lb;
    if (sgn)
      r.o = (s_ab > 64'sh7FFF_FFFF) || (s_ab < -64'sh8000_0000) ||
            (s_ac > 64'sh7FFF_FFFF) || (s_ac < -64'sh8000_0000) ||
            (s_f  > 64'sh7FFF_FFFF) || (s_f  < -64'sh8000_0000);
    else
      r.o = (s_ab > 64'shFFFF_FFFF) || (s_ac > 64'shFFFF_FFFF) || (s_f < 0);
    d = wrap(s_ab, sgn); e = wrap(s_ac, sgn); f = wrap(s_f, sgn);
    lt = (d < e);
    eq = (d == e);
    g  = lt ? d : e;
    h  = eq ? g : f;
    xv = wrap(lt ? 2 * g : g, sgn);
    zv = eq ? (h - (h & 1)) / 2 : h;   // floor halving == arithmetic/logical shift by one
    r.x = xv[31:0];
    r.z = zv[31:0];
    return r;
  endfunction

  function automatic bit [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 3));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    Rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c = '0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (out_valid_u !== 1'b0 || out_valid_s !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b/%b required 0/0", out_valid_u, out_valid_s);
    end
    n_cmp++;
    if (x_u !== 32'h0 || z_u !== 32'h0 || x_s !== 32'h0 || z_s !== 32'h0) begin
      n_err++; $display("FAIL reset_xz: got %h %h %h %h required all 0", x_u, z_u, x_s, z_s);
    end
    n_cmp++;
    if (in_ready_u !== 1'b1 || in_ready_s !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b/%b required 1/1", in_ready_u, in_ready_s);
    end
`ifdef CIRCUIT2_PIPE_OVF_EN
    n_cmp++;
    if (ovf_u !== 1'b0 || ovf_s !== 1'b0) begin
      n_err++; $display("FAIL reset_ovf: got %b/%b required 0/0", ovf_u, ovf_s);
    end
`endif
  endtask

  // Single operand triples through an empty pipe: latency, values, and output hold.
  task automatic test_directed();
    bit [31:0] ta [5] = '{32'd5, 32'd1, 32'd7, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
    bit [31:0] tb [5] = '{32'd3, 32'd2, 32'd2, 32'd0, 32'd1};
    bit [31:0] tc [5] = '{32'd1, 32'd4, 32'd2, 32'd0, 32'd0};
    bit [31:0] xu [5] = '{32'd6, 32'd6, 32'd9, 32'hFFFF_FFF8, 32'd0};
    bit [31:0] zu [5] = '{32'd2, 32'hFFFF_FFFF, 32'd4, 32'h7FFF_FFFC, 32'hFFFF_FFFE};
    bit [31:0] xs [5] = '{32'd6, 32'd6, 32'd9, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
    bit [31:0] zs [5] = '{32'd2, 32'hFFFF_FFFF, 32'd4, 32'hFFFF_FFFC, 32'hFFFF_FFFE};
    bit        ou [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int cnt;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1 in_valid = 1'b1; a = ta[i]; b = tb[i]; c = tc[i]; out_ready = 1'b1;
      @(negedge Clk);
      n_cmp++;
      if (in_ready_u !== 1'b1) begin
        n_err++; $display("FAIL dir%0d_in_ready: got %b required 1", i, in_ready_u);
      end
      @(posedge Clk);
      #1 in_valid = 1'b0; a = $urandom; b = $urandom; c = $urandom;
      cnt = 1;
      while (!out_valid_u && cnt < 10) begin
        @(posedge Clk);
        #1 cnt++;
      end
      n_cmp++;
      if (cnt !== 3 || out_valid_s !== 1'b1) begin
        n_err++; $display("FAIL dir%0d_latency: got %0d cycles (signed valid %b) required 3", i, cnt, out_valid_s);
      end
      n_cmp++;
      if (x_u !== xu[i] || z_u !== zu[i]) begin
        n_err++; $display("FAIL dir%0d_unsigned: got x=%h z=%h required x=%h z=%h", i, x_u, z_u, xu[i], zu[i]);
      end
      n_cmp++;
      if (x_s !== xs[i] || z_s !== zs[i]) begin
        n_err++; $display("FAIL dir%0d_signed: got x=%h z=%h required x=%h z=%h", i, x_s, z_s, xs[i], zs[i]);
      end
`ifdef CIRCUIT2_PIPE_OVF_EN
      n_cmp++;
      if (ovf_u !== ou[i] || ovf_s !== 1'b0) begin
        n_err++; $display("FAIL dir%0d_ovf: got %b/%b required %b/0", i, ovf_u, ovf_s, ou[i]);
      end
`else
      if (ou[i] && 1'b0) $display("unreachable");
`endif
      // Result drains on this edge; registers must keep it afterwards.
      @(posedge Clk);
      #1;
      n_cmp++;
      if (out_valid_u !== 1'b0 || x_u !== xu[i] || z_u !== zu[i]) begin
        n_err++; $display("FAIL dir%0d_hold: got valid=%b x=%h z=%h required valid=0 x=%h z=%h",
                          i, out_valid_u, x_u, z_u, xu[i], zu[i]);
      end
    end
  endtask

  // Streams n triples; sink stalled during cycles lo..hi, or random valid/ready when rnd.
  task automatic test_stream(input int n, input int lo, input int hi, input bit rnd);
    res_t qu[$], qs[$];
    res_t eu, es;
    int sent = 0, recv = 0, cyc = 0;
    logic exp_rdy;
    while ((sent < n || qu.size() > 0) && cyc < 3000) begin
      @(posedge Clk);
      #1;
      in_valid  = (sent < n) && (!rnd || $urandom_range(0, 2) != 0);
      a = pick(); b = pick(); c = pick();
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= lo && cyc <= hi);
      @(negedge Clk);
      exp_rdy = out_ready || (qu.size() < 3);
      n_cmp++;
      if (in_ready_u !== exp_rdy || in_ready_s !== exp_rdy) begin
        n_err++; $display("FAIL stream_in_ready cyc%0d: got %b/%b required %b", cyc, in_ready_u, in_ready_s, exp_rdy);
      end
      if (out_valid_u !== out_valid_s) begin
        n_cmp++; n_err++;
        $display("FAIL stream_valid_align cyc%0d: got %b/%b required equal", cyc, out_valid_u, out_valid_s);
      end
      if (out_valid_u && out_ready) begin
        n_cmp++;
        if (qu.size() == 0) begin
          n_err++; $display("FAIL stream_dup cyc%0d: got extra result x=%h required none", cyc, x_u);
        end else begin
          eu = qu.pop_front(); es = qs.pop_front();
          if (x_u !== eu.x || z_u !== eu.z || x_s !== es.x || z_s !== es.z) begin
            n_err++; $display("FAIL stream_data #%0d: got %h %h %h %h required %h %h %h %h",
                              recv, x_u, z_u, x_s, z_s, eu.x, eu.z, es.x, es.z);
          end
`ifdef CIRCUIT2_PIPE_OVF_EN
          n_cmp++;
          if (ovf_u !== eu.o || ovf_s !== es.o) begin
            n_err++; $display("FAIL stream_ovf #%0d: got %b/%b required %b/%b", recv, ovf_u, ovf_s, eu.o, es.o);
          end
`endif
          recv++;
        end
      end
      if (in_valid && in_ready_u) begin
        qu.push_back(model(a, b, c, 1'b0));
        qs.push_back(model(a, b, c, 1'b1));
        sent++;
      end
      if (!rnd && lo == 0 && cyc == hi) begin
        n_cmp++;
        if (sent !== 3) begin
          n_err++; $display("FAIL stream_fill_accepts: got %0d required 3", sent);
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (recv !== n || sent !== n) begin
      n_err++; $display("FAIL stream_count n=%0d: got sent=%0d recv=%0d required %0d/%0d", n, sent, recv, n, n);
    end
  endtask

  // Reset with three results in flight, then a fresh operand.
  task automatic test_reset_flight();
    int cnt;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1 in_valid = 1'b1; a = pick(); b = pick(); c = pick();
    end
    @(posedge Clk);
    #1 Rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; a = 32'd9; b = 32'd9; c = 32'd9;
    @(posedge Clk);
    #1 Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if (out_valid_u !== 1'b0 || out_valid_s !== 1'b0 || x_u !== 32'h0 || z_u !== 32'h0 || x_s !== 32'h0 || z_s !== 32'h0) begin
      n_err++; $display("FAIL flight_reset: got valid=%b x=%h z=%h required valid=0 x=0 z=0", out_valid_u, x_u, z_u);
    end
    n_cmp++;
    if (in_ready_u !== 1'b1) begin
      n_err++; $display("FAIL flight_in_ready: got %b required 1", in_ready_u);
    end
    @(posedge Clk);
    #1 in_valid = 1'b1; a = 32'd5; b = 32'd3; c = 32'd1; out_ready = 1'b1;
    @(posedge Clk);
    #1 in_valid = 1'b0;
    cnt = 1;
    while (!out_valid_u && cnt < 10) begin
      @(posedge Clk);
      #1 cnt++;
    end
    n_cmp++;
    if (cnt !== 3 || x_u !== 32'd6 || z_u !== 32'd2) begin
      n_err++; $display("FAIL flight_new: got %0d cycles x=%h z=%h required 3 cycles x=6 z=2", cnt, x_u, z_u);
    end
    @(posedge Clk);
    #1;
    n_cmp++;
    if (out_valid_u !== 1'b0) begin
      n_err++; $display("FAIL flight_drain: got out_valid=%b required 0", out_valid_u);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream(10, 4, 8, 1'b0);
    test_stream(6, 0, 5, 1'b0);
    test_stream(200, 0, 0, 1'b1);
    test_reset_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
